multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle control unit for the 32-bit processor datapath. It sequences instruction fetch, decode, execute, memory access and write-back over the shared PC, instruction register, register file, immediate extender, ALU and unified memory port. It decodes the 5-bit opcode (instruction bits 31:27) from the instruction register and drives every datapath select and write enable. It also detects halt, illegal opcodes and memory timeouts.

## Interface
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready before faulting; range 1..2^TIMEOUT_WIDTH-1.
- TIMEOUT_WIDTH, 8: width of the wait counter.

- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising clock edge.
- opcode  in  5  instruction register bits 31:27.
- alu_zero  in  1  ALU zero flag for the current ALU operation.
- mem_ready  in  1  memory completes the request this cycle.
- mem_request  out  1  memory access active.
- mem_write  out  1  1 = store, 0 = read; valid only while mem_request = 1.
- address_select  out  1  0 = PC, 1 = ALU result register.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_source  out  2  0 = ALU result (PC+4), 1 = ALU result register (branch target), 2 = extended jump immediate.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = extended immediate.
- alu_op  out  2  0 = add, 1 = subtract, 2 = function field, 3 = opcode-selected immediate operation.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU result register.
- halted  out  1  controller is in HALT.
- fault  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout.
- state  out  4  encoding of the current state, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, EXEC_R, EXEC_I, WRITEBACK, BRANCH, JUMP, HALT, FAULT.
- Output defaults in every state: all enables 0 and all selects 0, unless the state below sets them.
- FETCH:
  - Drives mem_request = 1, address_select = 0.
  - When mem_ready = 1 in the same cycle: ir_write = 1 and pc_write = 1 with alu_src_a = 0, alu_src_b = 1, alu_op = 0, pc_source = 0. Next state is DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 2, alu_op = 0, which precomputes the branch target into the ALU result register. Next state by opcode:
  - 0 or 2 → MEM_ADDR
  - 1 → EXEC_R
  - 3 or 12 → EXEC_I
  - 18 → BRANCH
  - 13 → JUMP
  - 31 → HALT
  - any other opcode → FAULT with fault = 1
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0. Next state is MEM_READ for opcode 0, MEM_WRITE for opcode 2.
- MEM_READ: mem_request = 1, address_select = 1. On mem_ready → WRITEBACK with mem_to_reg = 1.
- MEM_WRITE: mem_request = 1, mem_write = 1, address_select = 1. On mem_ready → FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 2. Next state is WRITEBACK with mem_to_reg = 0.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = 3. Next state is WRITEBACK with mem_to_reg = 0.
- WRITEBACK: reg_write = 1. mem_to_reg = 1 when entered from MEM_READ, otherwise 0; this flag is registered on entry. Next state is FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1. pc_write = alu_zero, pc_source = 1. Next state is FETCH.
- JUMP: pc_write = 1, pc_source = 2. Next state is FETCH.
- HALT and FAULT are terminal; only reset leaves them.
  - halted = 1 in HALT.
  - fault holds its value in FAULT.
  - mem_request = 0 in both.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE, and on mem_ready.
  - Increments every cycle that mem_request = 1 and mem_ready = 0.
  - When it equals MEM_TIMEOUT-1 and mem_ready = 0, the next state is FAULT with fault = 2.
  - mem_ready in that same cycle wins; no fault is raised.

## Timing
- Reset:
  - reset_n = 0 at a rising edge sets state = FETCH, clears the wait counter, sets fault = 0 and clears the write-back flag.
  - While reset_n = 0, all outputs are forced to 0.
  - reset_n overrides any in-flight memory access; mem_request drops combinationally when reset_n falls.
- Control outputs are combinational from state. The only combinational inputs are mem_ready (FETCH ir_write/pc_write) and alu_zero (BRANCH pc_write).
- Cycle counts with zero memory wait states (mem_ready high on the first request cycle):
  - R-type and I-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH and JUMP: 3 cycles.
- Each memory wait cycle adds one cycle.
- mem_request, mem_write and address_select stay stable from the first request cycle until mem_ready.

## Test plan
- Reset then ADD: hold reset_n = 0 for 2 cycles and check all outputs = 0. Release and feed opcode 1 with mem_ready = 1. Expect FETCH → DECODE → EXEC_R → WRITEBACK, reg_write = 1 exactly once, back in FETCH on cycle 5.
- LOAD with 3 wait cycles: opcode 0, mem_ready low for 3 cycles in MEM_READ. Expect mem_request = 1 and address_select = 1 for 4 cycles, then WRITEBACK with mem_to_reg = 1. Total 8 cycles.
- Branch: opcode 18. With alu_zero = 1 expect pc_write = 1 and pc_source = 1 in BRANCH. With alu_zero = 0 expect pc_write = 0. Both cases take 3 cycles.
- Timeout: MEM_TIMEOUT = 4, mem_ready stuck at 0 in FETCH. Expect FAULT after 4 request cycles with fault = 2 and mem_request = 0. Variant: mem_ready on the 4th cycle gives no fault.
- Illegal and halt:
  - Opcode 7 gives fault = 1 and the controller stays in FAULT for 20 cycles.
  - Opcode 31 gives halted = 1.
  - Reset from either state returns to FETCH with fault = 0.
- Reset mid-operation: assert reset_n = 0 during MEM_WRITE wait. Expect mem_request = 0 immediately and the next state = FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Purpose: multi-cycle control FSM sequencing fetch/decode/execute/memory/write-back for the 32-bit datapath.
// Latency: 3-5 cycles per instruction with zero memory wait states; each memory wait cycle adds one.
// Backpressure: memory stalls via mem_ready; a bounded wait counter faults the controller on timeout.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_request,
  output logic       mem_write,
  output logic       address_select,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [1:0] fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WRITE = 4'd4,
    S_EXEC_R    = 4'd5,
    S_EXEC_I    = 4'd6,
    S_WRITEBACK = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10,
    S_FAULT     = 4'd11
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LIMIT = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]               fault_q, fault_d;
  logic                     wb_mem_q, wb_mem_d;
  logic                     mem_phase;
  logic                     timeout;

  // State register plus wait counter, fault code and write-back source flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      fault_q    <= FAULT_NONE;
      wb_mem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      wb_mem_q   <= wb_mem_d;
    end
  end

  // Next-state decode, memory timeout detection and wait counter update
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    wb_mem_d   = wb_mem_q;
    wait_cnt_d = wait_cnt_q;
    mem_phase  = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    timeout    = mem_phase && !mem_ready && (wait_cnt_q == WAIT_LIMIT);

    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          5'd0, 5'd2:  state_d = S_MEM_ADDR;
          5'd1:        state_d = S_EXEC_R;
          5'd3, 5'd12: state_d = S_EXEC_I;
          5'd18:       state_d = S_BRANCH;
          5'd13:       state_d = S_JUMP;
          5'd31:       state_d = S_HALT;
          default: begin
            state_d = S_FAULT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == 5'd2) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_WRITEBACK;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    state_d = S_WRITEBACK;
      S_WRITEBACK,
      S_BRANCH,
      S_JUMP:      state_d = S_FETCH;
      S_HALT,
      S_FAULT:     state_d = state_q;
      default:     state_d = S_FETCH;
    endcase

    // A late mem_ready in the final allowed cycle beats the timeout
    if (timeout) begin
      state_d = S_FAULT;
      fault_d = FAULT_TIMEOUT;
    end

    // Remember the write-back source on entry so WRITEBACK needs no path history
    if ((state_d == S_WRITEBACK) && (state_q != S_WRITEBACK)) begin
      wb_mem_d = (state_q == S_MEM_READ);
    end

    // Any state change restarts the count, so every memory state starts from zero
    if (mem_ready || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (mem_phase) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Datapath controls decoded from the current state; reset forces everything low
  always_comb begin
    mem_request    = 1'b0;
    mem_write      = 1'b0;
    address_select = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_source      = 2'd0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'd0;
    alu_op         = 2'd0;
    reg_write      = 1'b0;
    mem_to_reg     = 1'b0;
    halted         = 1'b0;
    fault          = 2'd0;
    state          = 4'd0;
    if (reset_n) begin
      state = state_q;
      fault = fault_q;
      case (state_q)
        S_FETCH: begin
          mem_request = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd1;
          end
        end
        S_DECODE:    alu_src_b = 2'd2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_READ: begin
          mem_request    = 1'b1;
          address_select = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_request    = 1'b1;
          mem_write      = 1'b1;
          address_select = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = 2'd3;
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = wb_mem_q;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd1;
          pc_write  = alu_zero;
          pc_source = 2'd1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
        S_HALT:      halted = 1'b1;
        default:     ;
      endcase
    end
  end

endmodule
